// File: rtl/pong_interval_timer.sv
// Avalon-MM interval timer: programmable down-counter with one-shot/continuous
// modes, start/stop, coherent snapshot and a maskable level IRQ.
module pong_interval_timer #(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
  parameter bit          RUN_AT_RESET   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  // Bus handshake: a write is accepted in any cycle where chipselect is high
  // and write_n is low (no wait states); readdata is the registered view of
  // the register addressed in the previous cycle, and reads have no effects.

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam bit                     HAS_HIGH   = (COUNT_WIDTH > 16);
  localparam logic [COUNT_WIDTH-1:0] RST_PERIOD = DEFAULT_PERIOD[COUNT_WIDTH-1:0];
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

  run_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   cont_q, cont_d;
  logic                   ito_q, ito_d;
  logic                   to_q, to_d;
  logic [31:0]            snap_q, snap_d;
  logic [15:0]            readdata_q, readdata_d;

  logic        wr;
  logic        wr_status, wr_control, wr_period, wr_snap;
  logic        running, timeout_event;
  logic [31:0] period_ext, period_wr;

  logic unused_read_n;
  assign unused_read_n = read_n;

  always_comb begin
    wr         = chipselect & ~write_n;
    wr_status  = wr && (address == ADDR_STATUS);
    wr_control = wr && (address == ADDR_CONTROL);
    wr_snap    = wr && ((address == ADDR_SNAP_L) || (address == ADDR_SNAP_H));
    wr_period  = wr && ((address == ADDR_PERIOD_L) ||
                        ((address == ADDR_PERIOD_H) && HAS_HIGH));

    running       = (state_q == ST_RUNNING);
    timeout_event = running && (count_q == '0);

    // Merge the written half into a 32-bit image; excess bits drop on truncation.
    period_ext = 32'(period_q);
    period_wr  = period_ext;
    if (address == ADDR_PERIOD_L) begin
      period_wr = {period_ext[31:16], writedata};
    end else begin
      period_wr = {writedata, period_ext[15:0]};
    end

    period_d = period_q;
    if (wr_period) begin
      period_d = period_wr[COUNT_WIDTH-1:0];
    end

    count_d = count_q;
    if (wr_period) begin
      count_d = period_d;
    end else if (timeout_event) begin
      count_d = period_q;
    end else if (running) begin
      count_d = count_q - CNT_ONE;
    end

    cont_d = cont_q;
    ito_d  = ito_q;
    if (wr_control) begin
      ito_d  = writedata[0];
      cont_d = writedata[1];
    end

    // Later assignments take priority: period write, then STOP, then START.
    state_d = state_q;
    if (timeout_event && !cont_q) begin
      state_d = ST_STOPPED;
    end
    if (wr_control && writedata[2]) begin
      state_d = ST_RUNNING;
    end
    if (wr_control && writedata[3]) begin
      state_d = ST_STOPPED;
    end
    if (wr_period) begin
      state_d = ST_STOPPED;
    end

    to_d = to_q | timeout_event;
    if (wr_status) begin
      to_d = 1'b0;
    end

    snap_d = snap_q;
    if (wr_snap) begin
      snap_d = 32'(count_q);
    end

    case (address)
      ADDR_STATUS:   readdata_d = {14'd0, running, to_q};
      ADDR_CONTROL:  readdata_d = {14'd0, cont_q, ito_q};
      ADDR_PERIOD_L: readdata_d = period_ext[15:0];
      ADDR_PERIOD_H: readdata_d = period_ext[31:16];
      ADDR_SNAP_L:   readdata_d = snap_q[15:0];
      ADDR_SNAP_H:   readdata_d = snap_q[31:16];
      default:       readdata_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN_AT_RESET ? ST_RUNNING : ST_STOPPED;
      count_q    <= RST_PERIOD;
      period_q   <= RST_PERIOD;
      cont_q     <= RUN_AT_RESET;
      ito_q      <= 1'b0;
      to_q       <= 1'b0;
      snap_q     <= 32'd0;
      readdata_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      cont_q     <= cont_d;
      ito_q      <= ito_d;
      to_q       <= to_d;
      snap_q     <= snap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = to_q & ito_q;

endmodule

// File: tb/tb_pong_interval_timer.sv
// Directed bench for pong_interval_timer: a 32-bit instance with defaults and
// an 8-bit instance sharing the same bus.
module tb_pong_interval_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        irq;
  logic [15:0] readdata8;
  logic        irq8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pong_interval_timer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  pong_interval_timer #(.COUNT_WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata8), .irq(irq8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'd0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    check("rst_readdata8", readdata8, 16'h0000);
    reset_n = 1'b1;

    // Default continuous run: TO after 50000 clocks, irq masked
    bus_read(3'd0);
    check("status_after_reset", readdata, 16'h0002);
    repeat (49999) tick();
    check("status_before_first_to", readdata, 16'h0002);
    tick();
    check("status_first_to", readdata, 16'h0003);
    check("irq_masked", {15'd0, irq}, 16'h0000);

    // Period 9, continuous with ITO: TO every 10 clocks
    bus_write(3'd0, 16'h0000);
    bus_write(3'd2, 16'd9);
    bus_write(3'd3, 16'd0);
    bus_write(3'd1, 16'h0007);
    repeat (9) tick();
    check("p9_irq_before", {15'd0, irq}, 16'h0000);
    tick();
    check("p9_irq_rise", {15'd0, irq}, 16'h0001);
    repeat (5) tick();
    check("p9_irq_hold", {15'd0, irq}, 16'h0001);
    bus_write(3'd0, 16'h0000);
    check("p9_irq_fall", {15'd0, irq}, 16'h0000);
    repeat (3) tick();
    check("p9_irq_before_2nd", {15'd0, irq}, 16'h0000);
    tick();
    check("p9_irq_2nd", {15'd0, irq}, 16'h0001);

    // One-shot, period 4
    bus_write(3'd2, 16'd4);
    bus_write(3'd0, 16'h0000);
    bus_write(3'd1, 16'h0005);
    repeat (4) tick();
    check("os_irq_before", {15'd0, irq}, 16'h0000);
    tick();
    check("os_irq_rise", {15'd0, irq}, 16'h0001);
    bus_read(3'd0);
    check("os_status_stopped", readdata, 16'h0001);
    bus_write(3'd4, 16'h0000);
    bus_read(3'd4);
    check("os_snap_l_holds_period", readdata, 16'h0004);
    bus_read(3'd5);
    check("os_snap_h", readdata, 16'h0000);
    bus_write(3'd0, 16'h0000);
    check("os_irq_cleared", {15'd0, irq}, 16'h0000);
    repeat (100) tick();
    bus_read(3'd0);
    check("os_no_more_to", readdata, 16'h0000);
    check("os_irq_quiet", {15'd0, irq}, 16'h0000);

    // 32-bit period 0x0001_0003, coherent snapshots across the 16-bit boundary
    bus_write(3'd2, 16'h0003);
    bus_write(3'd3, 16'h0001);
    bus_write(3'd1, 16'h0006);
    repeat (2) tick();
    bus_write(3'd4, 16'h0000);
    bus_read(3'd4);
    check("snap1_l", readdata, 16'h0001);
    bus_read(3'd5);
    check("snap1_h", readdata, 16'h0001);
    bus_write(3'd5, 16'h0000);
    bus_read(3'd4);
    check("snap2_l", readdata, 16'hFFFE);
    bus_read(3'd5);
    check("snap2_h", readdata, 16'h0000);
    bus_read(3'd2);
    check("period_l", readdata, 16'h0003);
    bus_read(3'd3);
    check("period_h", readdata, 16'h0001);

    // STOP at 0x20, wait, START: timeout 33 clocks later
    bus_write(3'd2, 16'h0040);
    bus_write(3'd3, 16'h0000);
    bus_write(3'd1, 16'h0006);
    repeat (31) tick();
    bus_write(3'd1, 16'h000A);
    repeat (50) tick();
    bus_write(3'd4, 16'h0000);
    bus_read(3'd4);
    check("stop_snap_l", readdata, 16'h0020);
    bus_read(3'd5);
    check("stop_snap_h", readdata, 16'h0000);
    bus_write(3'd1, 16'h0006);
    address = 3'd0;
    repeat (33) tick();
    check("restart_before_to", readdata, 16'h0002);
    tick();
    check("restart_to", readdata, 16'h0003);
    bus_write(3'd1, 16'h000E);
    bus_read(3'd0);
    check("start_stop_status", readdata, 16'h0001);
    bus_read(3'd1);
    check("start_stop_control", readdata, 16'h0002);

    // STATUS write coincident with timeout leaves TO clear
    bus_write(3'd2, 16'd4);
    bus_write(3'd0, 16'h0000);
    bus_write(3'd1, 16'h0007);
    repeat (4) tick();
    bus_write(3'd0, 16'h0000);
    check("coinc_irq", {15'd0, irq}, 16'h0000);
    bus_read(3'd0);
    check("coinc_status", readdata, 16'h0002);
    check("coinc_irq_next", {15'd0, irq}, 16'h0000);
    repeat (3) tick();
    check("coinc_irq_before_next_to", {15'd0, irq}, 16'h0000);
    tick();
    check("coinc_irq_next_to", {15'd0, irq}, 16'h0001);

    // Width handling: 32-bit keeps PERIOD_H, 8-bit drops it
    bus_write(3'd2, 16'h1234);
    bus_write(3'd3, 16'h00AB);
    bus_read(3'd2);
    check("w32_period_l", readdata, 16'h1234);
    check("w8_period_l", readdata8, 16'h0034);
    bus_read(3'd3);
    check("w32_period_h", readdata, 16'h00AB);
    check("w8_period_h", readdata8, 16'h0000);
    bus_write(3'd5, 16'h0000);
    bus_read(3'd4);
    check("w32_snap_l", readdata, 16'h1234);
    check("w8_snap_l", readdata8, 16'h0034);
    bus_read(3'd5);
    check("w32_snap_h", readdata, 16'h00AB);
    check("w8_snap_h", readdata8, 16'h0000);

    // Asynchronous reset mid-count with irq active
    bus_write(3'd1, 16'h0007);
    repeat (5) tick();
    check("pre_reset_irq", {15'd0, irq}, 16'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {15'd0, irq}, 16'h0000);
    check("async_rst_readdata", readdata, 16'h0000);
    tick();
    reset_n = 1'b1;
    check("post_rst_irq", {15'd0, irq}, 16'h0000);
    bus_read(3'd0);
    check("post_rst_status", readdata, 16'h0002);
    check("post_rst_status8", readdata8, 16'h0002);
    bus_read(3'd1);
    check("post_rst_control", readdata, 16'h0002);
    bus_read(3'd2);
    check("post_rst_period_l", readdata, 16'hC34F);
    check("post_rst_period_l8", readdata8, 16'h004F);
    bus_read(3'd3);
    check("post_rst_period_h", readdata, 16'h0000);
    bus_read(3'd6);
    check("addr6_reads_zero", readdata, 16'h0000);
    check("post_rst_irq_quiet", {15'd0, irq}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
